// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSN_BYTES = 4;
  // Clears the byte-offset bits of a PC to form a word-aligned fetch address
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSN_BYTES - 1));

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: imem request/response, decode handoff and redirect input.
// master = fetch unit, slave = the memory/decode/branch side.
interface instr_fetch_unit_if #(parameter int unsigned XLEN = 32);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            ins_valid;
  logic            ins_ready;
  logic [XLEN-1:0] ins;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

  modport master (
    output imem_req_valid, imem_req_addr, ins_valid, ins,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, ins_ready,
           redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, ins_valid, ins,
    output imem_req_ready, imem_resp_valid, imem_resp_data, ins_ready,
           redirect_valid, redirect_target
  );

endinterface

// File: rtl/fetch_timeout_timer.sv
// Counts response-wait cycles; o_expired flags the last allowed wait cycle
// so the owner can leave the wait state on that same edge.
module fetch_timeout_timer #(
  parameter int unsigned CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_tick,
  output logic o_expired
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] r_count;

  // restart on every new request, otherwise count waiting cycles
  always_ff @(posedge clk) begin
    if (reset || i_start) r_count <= '0;
    else if (i_tick)      r_count <= r_count + W'(1);
  end

  assign o_expired = i_tick && (r_count == W'(CYCLES - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests the word at pc_in, holds it for decode and
// strobes the PC register with the sequential or redirected next PC.
// Optional response timeout: define FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_in,
  output logic [XLEN-1:0]  next_pc,
  output logic             update_pc,
  output logic             fetch_fault,
  instr_fetch_unit_if.master bus
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_ins;
  logic            r_discard;
  logic            r_fault;

  logic            w_req_valid;
  logic            w_ins_valid;
  logic            w_update;
  logic [XLEN-1:0] w_next_pc;
  logic            w_req_fire;
  logic            w_wait_tick;
  logic            w_expired;

  // handshake strobes and PC update; a redirect suppresses both handshakes
  // and wins over the sequential increment in its own cycle
  always_comb begin
    w_req_valid = 1'b0;
    w_ins_valid = 1'b0;
    w_update    = 1'b0;
    w_next_pc   = '0;
    if (!reset) begin
      if (r_state == S_REQ)  w_req_valid = !bus.redirect_valid;
      if (r_state == S_HOLD) w_ins_valid = !bus.redirect_valid;
      if (bus.redirect_valid) begin
        w_update  = 1'b1;
        w_next_pc = bus.redirect_target;
      end else if (w_ins_valid && bus.ins_ready) begin
        w_update  = 1'b1;
        w_next_pc = pc_in + XLEN'(INSN_BYTES);
      end
    end
  end

  assign w_req_fire  = w_req_valid && bus.imem_req_ready;
  assign w_wait_tick = (r_state == S_WAIT) && !bus.imem_resp_valid;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = reset ? '0 : (pc_in & ALIGN_MASK);
  assign bus.ins_valid      = w_ins_valid;
  assign bus.ins            = reset ? '0 : r_ins;
  assign next_pc            = w_next_pc;
  assign update_pc          = w_update;
  assign fetch_fault        = r_fault && !reset;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_req_fire),
    .i_tick    (w_wait_tick),
    .o_expired (w_expired)
  );
`else
  // without the timer S_WAIT waits for a response indefinitely
  assign w_expired = 1'b0;
`endif

  // fetch FSM: request -> wait for response -> hold for decode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_REQ;
      r_ins     <= '0;
      r_discard <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_req_fire) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            // the response answers a stale PC if a redirect came in meanwhile
            r_discard <= 1'b0;
            if (r_discard || bus.redirect_valid) begin
              r_state <= S_REQ;
            end else begin
              r_ins   <= bus.imem_resp_data;
              r_state <= S_HOLD;
            end
          end else if (bus.redirect_valid) begin
            r_discard <= 1'b1;
          end else if (w_expired) begin
            r_discard <= 1'b0;
            r_fault   <= 1'b1;
            r_state   <= S_FAULT;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid || (w_ins_valid && bus.ins_ready)) r_state <= S_REQ;
        end
        S_FAULT: begin
          if (bus.redirect_valid) begin
            r_fault <= 1'b0;
            r_state <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory/PC-register environment plus directed
// and randomized scenarios checked against an expected-PC model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] next_pc;
  logic        update_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .next_pc     (next_pc),
    .update_pc   (update_pc),
    .fetch_fault (fetch_fault),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  int lat_min = 1, lat_max = 1;
  bit rdy_rand = 0, mute = 0, spurious = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00500093;
      32'h0000_0004: return 32'h00A00113;
      default:       return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  // environment: PC register and instruction memory
  initial begin
    logic        acc, s_upd, s_rst;
    logic [31:0] s_nxt, s_addr, pend_addr;
    bit          pend;
    int          pend_cnt;
    pc_in = 0; pend = 0; pend_cnt = 0; pend_addr = 0;
    bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = 0;
    forever begin
      @(negedge clk);
      acc    = bus.imem_req_valid && bus.imem_req_ready;
      s_upd  = update_pc;
      s_nxt  = next_pc;
      s_addr = bus.imem_req_addr;
      s_rst  = reset;
      @(posedge clk); #1;
      if (s_rst) begin pc_in = 0; pend = 0; end
      else if (s_upd) pc_in = s_nxt;
      if (acc) begin pend = 1; pend_addr = s_addr; pend_cnt = $urandom_range(lat_max, lat_min); end
      bus.imem_resp_valid = 0;
      bus.imem_resp_data  = $urandom;
      if (pend) begin
        if (mute) pend = 0;
        else if (pend_cnt <= 1) begin
          bus.imem_resp_valid = 1; bus.imem_resp_data = mem_word(pend_addr); pend = 0;
        end else pend_cnt--;
      end else if (spurious && $urandom_range(3, 0) == 0) bus.imem_resp_valid = 1;
      bus.imem_req_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic wait_ins(output bit ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ins_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.imem_req_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  // ends one cycle after the accepted request, i.e. in the first wait cycle
  task automatic wait_fire(output bit ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) ok = 1;
      @(posedge clk); #1;
      if (ok) break;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.imem_req_valid); end
    total++; if (bus.ins_valid !== 1'b0) begin bad++; $display("FAIL reset_insv got=%b want=0", bus.ins_valid); end
    total++; if (update_pc !== 1'b0) begin bad++; $display("FAIL reset_upd got=%b want=0", update_pc); end
    total++; if (next_pc !== 32'h0) begin bad++; $display("FAIL reset_next got=%h want=0", next_pc); end
    total++; if (bus.ins !== 32'h0) begin bad++; $display("FAIL reset_ins got=%h want=0", bus.ins); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fetch_fault); end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_basic();
    bit          ev_req [6] = '{1, 0, 0, 1, 0, 0};
    bit          ev_ins [6] = '{0, 0, 1, 0, 0, 1};
    logic [31:0] ev_word[6] = '{32'h0, 32'h0, 32'h00500093, 32'h4, 32'h0, 32'h00A00113};
    logic [31:0] ev_next[6] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h8};
    bus.ins_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (bus.imem_req_valid !== ev_req[i]) begin bad++; $display("FAIL basic_req[%0d] got=%b want=%b", i, bus.imem_req_valid, ev_req[i]); end
      total++; if (bus.ins_valid !== ev_ins[i]) begin bad++; $display("FAIL basic_insv[%0d] got=%b want=%b", i, bus.ins_valid, ev_ins[i]); end
      total++; if (update_pc !== ev_ins[i]) begin bad++; $display("FAIL basic_upd[%0d] got=%b want=%b", i, update_pc, ev_ins[i]); end
      if (ev_ins[i]) begin
        total++; if (bus.ins !== ev_word[i]) begin bad++; $display("FAIL basic_ins[%0d] got=%h want=%h", i, bus.ins, ev_word[i]); end
        total++; if (next_pc !== ev_next[i]) begin bad++; $display("FAIL basic_next[%0d] got=%h want=%h", i, next_pc, ev_next[i]); end
      end else if (ev_req[i]) begin
        total++; if (bus.imem_req_addr !== ev_word[i]) begin bad++; $display("FAIL basic_addr[%0d] got=%h want=%h", i, bus.imem_req_addr, ev_word[i]); end
      end
      if (i == 0) begin
        total++; if (bus.ins !== 32'h0) begin bad++; $display("FAIL basic_ins_init got=%h want=0", bus.ins); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    bit ok;
    bus.ins_ready = 0;
    wait_ins(ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_wait got=timeout want=ins_valid"); end
    if (ok) begin
      for (int c = 0; c < 5; c++) begin
        if (c > 0) begin @(posedge clk); #1; @(negedge clk); end
        total++; if (bus.ins_valid !== 1'b1) begin bad++; $display("FAIL stall_insv[%0d] got=%b want=1", c, bus.ins_valid); end
        total++; if (bus.ins !== mem_word(32'h8)) begin bad++; $display("FAIL stall_ins[%0d] got=%h want=%h", c, bus.ins, mem_word(32'h8)); end
        total++; if (update_pc !== 1'b0) begin bad++; $display("FAIL stall_upd[%0d] got=%b want=0", c, update_pc); end
        total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%b want=0", c, bus.imem_req_valid); end
      end
      @(posedge clk); #1;
      bus.ins_ready = 1;
      @(negedge clk);
      total++; if (update_pc !== 1'b1 || next_pc !== 32'hC) begin bad++; $display("FAIL stall_release got=%b/%h want=1/0000000c", update_pc, next_pc); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    lat_min = 3; lat_max = 3;
    bus.ins_ready = 1;
    wait_fire(ok);
    total++; if (!ok) begin bad++; $display("FAIL rw_fire got=timeout want=handshake"); end
    bus.redirect_valid = 1; bus.redirect_target = 32'h100;
    @(negedge clk);
    total++; if (update_pc !== 1'b1 || next_pc !== 32'h100) begin bad++; $display("FAIL rw_redirect got=%b/%h want=1/00000100", update_pc, next_pc); end
    @(posedge clk); #1;
    bus.redirect_valid = 0;
    lat_min = 1; lat_max = 1;
    wait_req(ok);
    total++; if (!ok || bus.imem_req_addr !== 32'h100) begin bad++; $display("FAIL rw_addr got=%h ok=%b want=00000100", bus.imem_req_addr, ok); end
    if (ok) begin @(posedge clk); #1; end
    wait_ins(ok);
    total++; if (!ok || bus.ins !== mem_word(32'h100)) begin bad++; $display("FAIL rw_ins got=%h want=%h", bus.ins, mem_word(32'h100)); end
    total++; if (next_pc !== 32'h104) begin bad++; $display("FAIL rw_next got=%h want=00000104", next_pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_redirect_hold();
    bit ok;
    bus.ins_ready = 0;
    wait_ins(ok);
    total++; if (!ok) begin bad++; $display("FAIL rh_wait got=timeout want=ins_valid"); end
    @(posedge clk); #1;
    bus.ins_ready = 1; bus.redirect_valid = 1; bus.redirect_target = 32'h200;
    @(negedge clk);
    total++; if (bus.ins_valid !== 1'b0) begin bad++; $display("FAIL rh_insv got=%b want=0", bus.ins_valid); end
    total++; if (update_pc !== 1'b1 || next_pc !== 32'h200) begin bad++; $display("FAIL rh_redirect got=%b/%h want=1/00000200", update_pc, next_pc); end
    @(posedge clk); #1;
    bus.redirect_valid = 0;
    wait_ins(ok);
    total++; if (!ok || bus.ins !== mem_word(32'h200)) begin bad++; $display("FAIL rh_ins got=%h want=%h", bus.ins, mem_word(32'h200)); end
    total++; if (next_pc !== 32'h204) begin bad++; $display("FAIL rh_next got=%h want=00000204", next_pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    bit ok;
    bus.redirect_valid = 1; bus.redirect_target = 32'hFFFF_FFFC;
    @(negedge clk);
    total++; if (next_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_redirect got=%h want=fffffffc", next_pc); end
    @(posedge clk); #1;
    bus.redirect_valid = 0;
    wait_ins(ok);
    total++; if (!ok || bus.ins !== mem_word(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_ins got=%h want=%h", bus.ins, mem_word(32'hFFFF_FFFC)); end
    total++; if (update_pc !== 1'b1 || next_pc !== 32'h0) begin bad++; $display("FAIL wrap_next got=%b/%h want=1/00000000", update_pc, next_pc); end
    @(posedge clk); #1;
    wait_req(ok);
    total++; if (!ok || bus.imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h want=00000000", bus.imem_req_addr); end
    if (ok) begin @(posedge clk); #1; end
    wait_ins(ok);
    total++; if (!ok || bus.ins !== 32'h00500093) begin bad++; $display("FAIL wrap_ins0 got=%h want=00500093", bus.ins); end
    @(posedge clk); #1;
  endtask

  // model: exp_pc is the PC of the next instruction decode must receive
  task automatic test_random();
    logic [31:0] exp_pc, tgt;
    bit          rd;
    int          delivered;
    exp_pc = 0; delivered = 0;
    lat_min = 1; lat_max = 4; rdy_rand = 1; spurious = 1;
    for (int n = 0; n < 400; n++) begin
      rd  = (n == 0) || ($urandom_range(99, 0) < 8);
      tgt = $urandom;
      if ($urandom_range(3, 0) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(4, 0) == 0) tgt = tgt | 32'hFFFF_FFF0;
      bus.redirect_valid  = rd;
      bus.redirect_target = tgt;
      bus.ins_ready       = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (rd) begin
        total++; if (update_pc !== 1'b1 || next_pc !== tgt) begin bad++; $display("FAIL rnd_redirect[%0d] got=%b/%h want=1/%h", n, update_pc, next_pc, tgt); end
        total++; if (bus.ins_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rnd_suppress[%0d] got=%b/%b want=0/0", n, bus.ins_valid, bus.imem_req_valid); end
        exp_pc = tgt;
      end else begin
        if (bus.ins_valid && bus.ins_ready) begin
          total++; if (bus.ins !== mem_word(exp_pc & 32'hFFFF_FFFC)) begin bad++; $display("FAIL rnd_ins[%0d] got=%h want=%h", n, bus.ins, mem_word(exp_pc & 32'hFFFF_FFFC)); end
          total++; if (update_pc !== 1'b1 || next_pc !== exp_pc + 32'd4) begin bad++; $display("FAIL rnd_next[%0d] got=%b/%h want=1/%h", n, update_pc, next_pc, exp_pc + 32'd4); end
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end else begin
          total++; if (update_pc !== 1'b0) begin bad++; $display("FAIL rnd_upd[%0d] got=%b want=0", n, update_pc); end
        end
        if (bus.imem_req_valid) begin
          total++; if (bus.imem_req_addr !== (exp_pc & 32'hFFFF_FFFC)) begin bad++; $display("FAIL rnd_addr[%0d] got=%h want=%h", n, bus.imem_req_addr, exp_pc & 32'hFFFF_FFFC); end
        end
      end
      total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL rnd_fault[%0d] got=%b want=0", n, fetch_fault); end
      @(posedge clk); #1;
    end
    bus.redirect_valid = 0; bus.ins_ready = 1;
    rdy_rand = 0; spurious = 0; lat_min = 1; lat_max = 1;
    total++; if (delivered < 10) begin bad++; $display("FAIL rnd_progress got=%0d want>=10", delivered); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    bus.ins_ready = 1;
    wait_ins(ok);
    @(posedge clk); #1;
    mute = 1;
    wait_fire(ok);
    total++; if (!ok) begin bad++; $display("FAIL to_fire got=timeout want=handshake"); end
    for (int w = 1; w <= 8; w++) begin
      @(negedge clk);
      total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL to_early[%0d] got=%b want=0", w, fetch_fault); end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (fetch_fault !== 1'b1 || bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL to_fault[%0d] got=%b/%b want=1/0", c, fetch_fault, bus.imem_req_valid); end
      @(posedge clk); #1;
    end
    mute = 0;
    bus.redirect_valid = 1; bus.redirect_target = 32'h40;
    @(negedge clk);
    total++; if (update_pc !== 1'b1 || next_pc !== 32'h40) begin bad++; $display("FAIL to_redirect got=%b/%h want=1/00000040", update_pc, next_pc); end
    @(posedge clk); #1;
    bus.redirect_valid = 0;
    @(negedge clk);
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", fetch_fault); end
    @(posedge clk); #1;
    wait_ins(ok);
    total++; if (!ok || bus.ins !== mem_word(32'h40)) begin bad++; $display("FAIL to_ins got=%h want=%h", bus.ins, mem_word(32'h40)); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    reset = 1;
    bus.ins_ready = 0; bus.redirect_valid = 0; bus.redirect_target = 0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_random();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
